// File: rtl/lfsr_arb_pkg.sv
// Shared types and the LFSR step function for the burst arbiter and its bench.
package lfsr_arb_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} arb_state_e;

    localparam int LFSR_MAX_W = 32;

    // Operands are zero-extended to LFSR_MAX_W; the feedback bit lands at bit width-1.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] tap,
        input int unsigned           width
    );
        logic fb;
        fb = ^(state & tap);
        return (state >> 1) | ({{(LFSR_MAX_W-1){1'b0}}, fb} << (width - 1));
    endfunction

endpackage

// File: rtl/lfsr_step_core.sv
// Shared LFSR engine: holds state and tap, load wins over advance.
// Optional LFSR_LOCKUP_GUARD_EN keeps the state out of the all-zero lockup.
module lfsr_step_core
    import lfsr_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [DATA_WIDTH-1:0] tap,
    input  logic                  advance,
    output logic [DATA_WIDTH-1:0] state
);

    logic [DATA_WIDTH-1:0] tap_q;
    logic [DATA_WIDTH-1:0] nxt_raw;
    logic [DATA_WIDTH-1:0] nxt;
    logic [DATA_WIDTH-1:0] seed_eff;
    logic [LFSR_MAX_W-1:0] nxt_full;

    assign nxt_full = lfsr_next(LFSR_MAX_W'(state), LFSR_MAX_W'(tap_q), unsigned'(DATA_WIDTH));
    assign nxt_raw  = nxt_full[DATA_WIDTH-1:0];

    generate
        if (DATA_WIDTH < LFSR_MAX_W) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^nxt_full[LFSR_MAX_W-1:DATA_WIDTH];
        end
    endgenerate

`ifdef LFSR_LOCKUP_GUARD_EN
    assign seed_eff = (seed == '0)    ? DATA_WIDTH'(1) : seed;
    assign nxt      = (nxt_raw == '0) ? DATA_WIDTH'(1) : nxt_raw;
`else
    assign seed_eff = seed;
    assign nxt      = nxt_raw;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= '0;
            tap_q <= '0;
        end else if (load) begin
            state <= seed_eff;
            tap_q <= tap;
        end else if (advance) begin
            state <= nxt;
        end
    end

endmodule

// File: rtl/lfsr_burst_arbiter.sv
// Round-robin arbiter that lends one LFSR engine to NUM_REQ requesters and
// streams bursts of pseudo-random words. Optional macro: LFSR_LOCKUP_GUARD_EN.
module lfsr_burst_arbiter
    import lfsr_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int LEN_WIDTH  = 8,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_seed,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_tap,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
    output logic [NUM_REQ-1:0]              gnt,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [ID_W-1:0]                 out_id,
    output logic                            out_last,
    output logic                            busy
);

    arb_state_e            st;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       id_q;
    logic [ID_W-1:0]       next_ptr;
    logic [DATA_WIDTH-1:0] seed_q;
    logic [DATA_WIDTH-1:0] tap_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  cnt;
    logic [DATA_WIDTH-1:0] eng_state;
    logic                  sel_found;
    logic [ID_W-1:0]       sel_id;
    logic                  hs;
    logic                  last_w;

    // First requester at or after the rr pointer, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!sel_found && req[idx]) begin
                sel_found = 1'b1;
                sel_id    = ID_W'(idx);
            end
        end
    end

    assign next_ptr = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
    assign hs       = out_valid & out_ready;
    assign last_w   = (cnt == len_q - LEN_WIDTH'(1));
    assign out_last = out_valid & last_w;
    assign out_data = out_valid ? eng_state : '0;

    lfsr_step_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
        .clk     (clk),
        .reset   (reset),
        .load    (st == LOAD),
        .seed    (seed_q),
        .tap     (tap_q),
        .advance (hs),
        .state   (eng_state)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= IDLE;
            gnt       <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
            busy      <= 1'b0;
            rr_ptr    <= '0;
            id_q      <= '0;
            cnt       <= '0;
            seed_q    <= '0;
            tap_q     <= '0;
            len_q     <= '0;
        end else begin
            case (st)
                IDLE: begin
                    gnt <= '0;
                    if (sel_found) begin
                        seed_q <= req_seed[sel_id*DATA_WIDTH +: DATA_WIDTH];
                        tap_q  <= req_tap[sel_id*DATA_WIDTH +: DATA_WIDTH];
                        len_q  <= req_len[sel_id*LEN_WIDTH +: LEN_WIDTH];
                        id_q   <= sel_id;
                        gnt    <= NUM_REQ'(1) << sel_id;
                        busy   <= 1'b1;
                        st     <= LOAD;
                    end
                end
                LOAD: begin
                    gnt <= '0;
                    cnt <= '0;
                    if (len_q == '0) begin
                        st     <= IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr;
                    end else begin
                        st        <= RUN;
                        out_valid <= 1'b1;
                        out_id    <= id_q;
                    end
                end
                RUN: begin
                    if (hs) begin
                        cnt <= cnt + 1'b1;
                        if (last_w) begin
                            st        <= IDLE;
                            out_valid <= 1'b0;
                            out_id    <= '0;
                            busy      <= 1'b0;
                            rr_ptr    <= next_ptr;
                        end
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule
